// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: steps each instruction through IF/ID/EXE/MEM/WB,
// drives datapath strobes, handles the data-memory wait handshake and counts retirements.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ext_sel,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned OP_W     = 6;
  localparam int unsigned TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    I_ILL, I_ADD, I_SUB, I_SLT, I_SLTU, I_ORI, I_ADDIU,
    I_LW, I_SW, I_BEQ, I_J, I_HALT
  } ins_e;

  // Maps an opcode/func pair onto the supported instruction class.
  function automatic ins_e decode(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
    ins_e r;
    r = I_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000:            r = I_ADD;
          6'b100010, 6'b100011: r = I_SUB;
          6'b101010:            r = I_SLT;
          6'b101011:            r = I_SLTU;
          default:              r = I_ILL;
        endcase
      end
      6'b001101: r = I_ORI;
      6'b001001: r = I_ADDIU;
      6'b100011: r = I_LW;
      6'b101011: r = I_SW;
      6'b000100: r = I_BEQ;
      6'b000010: r = I_J;
      6'b111111: r = I_HALT;
      default:   r = I_ILL;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OP_W-1:0]   func_q, func_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  ins_e id_ins_c;
  ins_e lat_ins_c;
  logic retire_c;
  logic tmo_hit_c;

  // ID decodes the live IR; later states use the copy captured in ID.
  assign id_ins_c  = decode(opcode, func);
  assign lat_ins_c = decode(op_q, func_q);
  assign tmo_hit_c = (MEM_TIMEOUT != 0) && (tmo_q == TMO_W'(TMO_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      op_q      <= '0;
      func_q    <= '0;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      func_q    <= func_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    func_d    = func_q;
    tmo_d     = '0;
    illegal_d = illegal_q;
    retire_c  = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        op_d   = opcode;
        func_d = func;
        case (id_ins_c)
          I_J:    begin retire_c = 1'b1; state_d = S_IF;   end
          I_HALT: begin retire_c = 1'b1; state_d = S_HALT; end
          I_ILL:  begin illegal_d = 1'b1; state_d = S_HALT; end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (lat_ins_c)
          I_BEQ:      begin retire_c = 1'b1; state_d = S_IF; end
          I_LW, I_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // A ready in the last allowed cycle still completes the access.
        if (mem_ready) begin
          if (lat_ins_c == I_SW) begin
            retire_c = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit_c) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB: begin
        retire_c = 1'b1;
        state_d  = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    retired_d = retired_q + (retire_c ? CNT_W'(1) : CNT_W'(0));
  end

  always_comb begin
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ext_sel    = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 3'b000;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IF: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        pc_src   = 2'b00;
      end
      S_ID: begin
        if (id_ins_c == I_J) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
      end
      S_EXE: begin
        case (lat_ins_c)
          I_SUB:  alu_op = 3'b001;
          I_SLT:  alu_op = 3'b011;
          I_SLTU: alu_op = 3'b100;
          I_ORI:  begin alu_op = 3'b010; alu_src_b = 1'b1; end
          I_ADDIU, I_LW, I_SW: begin
            alu_op    = 3'b000;
            alu_src_b = 1'b1;
            ext_sel   = 1'b1;
          end
          I_BEQ: begin
            alu_op   = 3'b001;
            ext_sel  = 1'b1;
            pc_write = zero;
            pc_src   = 2'b01;
          end
          default: alu_op = 3'b000;
        endcase
      end
      S_MEM: begin
        // Reset abandons an outstanding request in the same cycle.
        mem_read  = (lat_ins_c == I_LW) && !reset;
        mem_write = (lat_ins_c == I_SW) && !reset;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (lat_ins_c == I_ADD) || (lat_ins_c == I_SUB) ||
                     (lat_ins_c == I_SLT) || (lat_ins_c == I_SLTU);
        mem_to_reg = (lat_ins_c == I_LW);
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign state         = state_q;
  assign illegal       = illegal_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: literal vector table, directed multi-cycle sequences and
// random instruction streams checked against an instruction-level reference model.
module tb_mc_control_fsm;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode, func;
  logic             zero, mem_ready;
  logic [2:0]       state;
  logic             ir_load, pc_write, ext_sel, alu_src_b;
  logic [1:0]       pc_src;
  logic [2:0]       alu_op;
  logic             reg_dst, mem_to_reg, reg_write, mem_read, mem_write, halted, illegal;
  logic [CNT_W-1:0] retired_count;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .state(state), .ir_load(ir_load), .pc_write(pc_write),
    .pc_src(pc_src), .ext_sel(ext_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .illegal(illegal),
    .retired_count(retired_count)
  );

  typedef enum {K_R, K_ORI, K_ADDIU, K_LW, K_SW, K_BEQ, K_J, K_HALT, K_ILL} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         any_fn;
    kind_e      k;
    logic [2:0] aop;
    logic       asb;
    logic       ext;
  } ins_t;

  // One clock of stimulus plus the expected outputs for that clock.
  typedef struct {
    logic             rst;
    logic [5:0]       op;
    logic [5:0]       fn;
    logic             zero;
    logic             rdy;
    logic             chk;
    logic             chk_ext;
    logic [2:0]       st;
    logic [15:0]      ctl;
    logic [CNT_W-1:0] ret;
  } vec_t;

  ins_t isa [12];
  vec_t q[$];
  vec_t tbl [8];
  int   checks = 0;
  int   errors = 0;
  int   m_ret  = 0;
  bit   m_il   = 0;
  bit   m_halt = 0;
  int   mr_cycles = 0;
  int   mw_cycles = 0;

  function automatic ins_t mi(input logic [5:0] op, input logic [5:0] fn, input bit any,
                              input kind_e k, input logic [2:0] aop, input logic asb,
                              input logic ext);
    ins_t r;
    r.op = op; r.fn = fn; r.any_fn = any; r.k = k; r.aop = aop; r.asb = asb; r.ext = ext;
    return r;
  endfunction

  function automatic logic [15:0] mk(input logic ir, input logic pw, input logic [1:0] ps,
                                     input logic ext, input logic asb, input logic [2:0] aop,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic mr, input logic mw, input logic h,
                                     input logic il);
    return {ir, pw, ps, ext, asb, aop, rd, m2r, rw, mr, mw, h, il};
  endfunction

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] st,
                               input logic [15:0] ctl, input logic [CNT_W-1:0] ret);
    vec_t v;
    v.rst = 1'b0; v.op = op; v.fn = fn; v.zero = 1'b0; v.rdy = 1'b1;
    v.chk = 1'b1; v.chk_ext = 1'b1; v.st = st; v.ctl = ctl; v.ret = ret;
    return v;
  endfunction

  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < 12; i++)
      if (isa[i].op == op && (isa[i].any_fn || isa[i].fn == fn)) return i;
    return -1;
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic bump();
    m_ret = (m_ret + 1) % (1 << CNT_W);
  endtask

  task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic chk, input logic chk_ext,
                      input logic [2:0] st, input logic [15:0] ctl);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy;
    v.chk = chk; v.chk_ext = chk_ext; v.st = st; v.ctl = ctl; v.ret = CNT_W'(m_ret);
    q.push_back(v);
  endtask

  // Expands one instruction into its expected per-cycle trace; waits = MEM cycles before ready.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int waits);
    int         ix;
    kind_e      k;
    logic [2:0] aop;
    logic       asb, ext, r;
    ix  = find(op, fn);
    k   = (ix < 0) ? K_ILL : isa[ix].k;
    aop = (ix < 0) ? 3'b000 : isa[ix].aop;
    asb = (ix < 0) ? 1'b0 : isa[ix].asb;
    ext = (ix < 0) ? 1'b0 : isa[ix].ext;
    push(1'b0, op, fn, rb(), rb(), 1'b1, 1'b1, 3'd0,
         mk(1, 1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, m_il));
    push(1'b0, op, fn, rb(), rb(), 1'b1, 1'b1, 3'd1,
         mk(0, k == K_J, (k == K_J) ? 2'b10 : 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, m_il));
    if (k == K_J)    begin bump(); return; end
    if (k == K_HALT) begin bump(); m_halt = 1; return; end
    if (k == K_ILL)  begin m_il = 1; m_halt = 1; return; end
    if (k == K_BEQ) begin
      push(1'b0, r6(), r6(), z, rb(), 1'b1, 1'b0, 3'd2,
           mk(0, z, 2'b01, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, m_il));
      bump();
      return;
    end
    push(1'b0, r6(), r6(), z, rb(), 1'b1, 1'b1, 3'd2,
         mk(0, 0, 2'b00, ext, asb, aop, 0, 0, 0, 0, 0, 0, m_il));
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < 1000; i++) begin
        r = (i >= waits);
        push(1'b0, r6(), r6(), rb(), r, 1'b1, 1'b1, 3'd3,
             mk(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, k == K_LW, k == K_SW, 0, m_il));
        if (r) begin
          if (k == K_SW) begin bump(); return; end
          break;
        end
        if (MEM_TIMEOUT != 0 && i == int'(MEM_TIMEOUT) - 1) begin
          m_il = 1; m_halt = 1;
          return;
        end
      end
    end
    push(1'b0, r6(), r6(), rb(), rb(), 1'b1, 1'b1, 3'd4,
         mk(0, 0, 2'b00, 0, 0, 3'b000, k == K_R, k == K_LW, 1, 0, 0, 0, m_il));
    bump();
  endtask

  task automatic add_halt(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, r6(), r6(), rb(), rb(), 1'b1, 1'b1, 3'd5,
           mk(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, m_il));
  endtask

  task automatic add_reset();
    push(1'b1, r6(), r6(), rb(), rb(), 1'b0, 1'b0, 3'd0, 16'h0000);
    m_ret = 0; m_il = 0; m_halt = 0;
  endtask

  // Replaces cycle p (and everything after it) of the trace with a reset cycle.
  task automatic cut_reset(input int p);
    vec_t v;
    while (q.size() > p + 1) void'(q.pop_back());
    v = q[p]; v.rst = 1'b1; v.chk = 1'b0; q[p] = v;
    m_ret = 0; m_il = 0; m_halt = 0;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run(input string name);
    vec_t        e;
    logic [18:0] act, expv, mask;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      reset = e.rst; opcode = e.op; func = e.fn; zero = e.zero; mem_ready = e.rdy;
      #1;
      if (e.chk) begin
        act  = {state, ir_load, pc_write, pc_src, ext_sel, alu_src_b, alu_op, reg_dst,
                mem_to_reg, reg_write, mem_read, mem_write, halted, illegal};
        expv = {e.st, e.ctl};
        mask = e.chk_ext ? '1 : ~(19'(1) << 11);
        checks++;
        if ((act & mask) != (expv & mask)) begin
          errors++;
          $display("FAIL %s[%0d] st/ctl: got %05h expected %05h", name, i, act, expv);
        end
        checks++;
        if (retired_count != e.ret) begin
          errors++;
          $display("FAIL %s[%0d] retired_count: got %0d expected %0d", name, i,
                   retired_count, e.ret);
        end
      end
      if (mem_read)  mr_cycles++;
      if (mem_write) mw_cycles++;
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  initial begin
    int         ix, w, n0;
    logic [5:0] op, fn;

    isa[0]  = mi(6'b000000, 6'b100000, 0, K_R,     3'b000, 0, 0);
    isa[1]  = mi(6'b000000, 6'b100010, 0, K_R,     3'b001, 0, 0);
    isa[2]  = mi(6'b000000, 6'b100011, 0, K_R,     3'b001, 0, 0);
    isa[3]  = mi(6'b000000, 6'b101010, 0, K_R,     3'b011, 0, 0);
    isa[4]  = mi(6'b000000, 6'b101011, 0, K_R,     3'b100, 0, 0);
    isa[5]  = mi(6'b001101, 6'b000000, 1, K_ORI,   3'b010, 1, 0);
    isa[6]  = mi(6'b001001, 6'b000000, 1, K_ADDIU, 3'b000, 1, 1);
    isa[7]  = mi(6'b100011, 6'b000000, 1, K_LW,    3'b000, 1, 1);
    isa[8]  = mi(6'b101011, 6'b000000, 1, K_SW,    3'b000, 1, 1);
    isa[9]  = mi(6'b000100, 6'b000000, 1, K_BEQ,   3'b001, 0, 0);
    isa[10] = mi(6'b000010, 6'b000000, 1, K_J,     3'b000, 0, 0);
    isa[11] = mi(6'b111111, 6'b000000, 1, K_HALT,  3'b000, 0, 0);

    // add then sltu, mem_ready tied high
    tbl[0] = mkv(6'b000000, 6'b100000, 3'd0, 16'hC000, 4'd0);
    tbl[1] = mkv(6'b000000, 6'b100000, 3'd1, 16'h0000, 4'd0);
    tbl[2] = mkv(6'b000000, 6'b100000, 3'd2, 16'h0000, 4'd0);
    tbl[3] = mkv(6'b000000, 6'b100000, 3'd4, 16'h0050, 4'd0);
    tbl[4] = mkv(6'b000000, 6'b101011, 3'd0, 16'hC000, 4'd1);
    tbl[5] = mkv(6'b000000, 6'b101011, 3'd1, 16'h0000, 4'd1);
    tbl[6] = mkv(6'b000000, 6'b101011, 3'd2, 16'h0200, 4'd1);
    tbl[7] = mkv(6'b000000, 6'b101011, 3'd4, 16'h0050, 4'd1);

    reset = 1'b1; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) q.push_back(tbl[i]);
    run("table_add_sltu");
    check_int("retired_after_8", int'(retired_count), 2);

    add_reset();
    add_instr(6'b100011, r6(), 1'b0, 3);
    mr_cycles = 0;
    run("lw_wait3");
    check_int("lw_mem_read_cycles", mr_cycles, 4);

    add_reset();
    add_instr(6'b000100, r6(), 1'b1, 0);
    add_instr(6'b000100, r6(), 1'b0, 0);
    run("beq_taken_not_taken");

    add_reset();
    add_instr(6'b000010, r6(), 1'b0, 0);
    add_instr(6'b011111, r6(), 1'b0, 0);
    add_halt(20);
    run("j_then_illegal");

    add_reset();
    add_instr(6'b101011, r6(), 1'b0, 1000);
    add_halt(3);
    mw_cycles = 0;
    run("sw_timeout");
    check_int("sw_mem_write_cycles", mw_cycles, int'(MEM_TIMEOUT));

    add_reset();
    n0 = q.size();
    add_instr(6'b100011, r6(), 1'b0, 5);
    cut_reset(n0 + 4);
    add_instr(6'b000000, 6'b100000, 1'b0, 0);
    run("reset_mid_lw");

    add_reset();
    for (int n = 0; n < 250; n++) begin
      if (m_halt) begin
        add_halt(int'($urandom_range(1, 3)));
        add_reset();
      end
      if ($urandom_range(0, 6) == 0) begin
        op = r6(); fn = r6();
      end else begin
        ix = int'($urandom_range(0, 11));
        op = isa[ix].op;
        fn = isa[ix].any_fn ? r6() : isa[ix].fn;
      end
      w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                       : int'($urandom_range(0, 3));
      n0 = q.size();
      add_instr(op, fn, rb(), w);
      if ($urandom_range(0, 19) == 0)
        cut_reset(n0 + int'($urandom_range(0, q.size() - n0 - 1)));
    end
    run("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
